// File: rtl/gcd_controller.sv
// Control FSM for the subtract-and-compare GCD datapath.
// Moore outputs, iteration counter with saturating abort limit.
module gcd_controller #(
  parameter int unsigned          CNT_W    = 16,
  parameter logic [CNT_W-1:0]     MAX_ITER = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADA,
    S_LOADB,
    S_CHECK,
    S_SUBA,
    S_SUBB,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOADA;
          cnt_d   = '0;
        end
      end
      S_LOADA: state_d = S_LOADB;
      S_LOADB: state_d = S_CHECK;
      S_CHECK: begin
        // eq wins over the limit so an exact finish is never aborted
        if (eq)                    state_d = S_DONE;
        else if (cnt_q == MAX_ITER) state_d = S_ERR;
        else if (gt)               state_d = S_SUBA;
        else if (lt)               state_d = S_SUBB;
        else                       state_d = S_ERR;
      end
      S_SUBA, S_SUBB: begin
        state_d = S_CHECK;
        if (cnt_q != MAX_ITER) cnt_d = cnt_q + ONE;
      end
      S_DONE, S_ERR: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ldA    = 1'b0;
    ldB    = 1'b0;
    sel1   = 1'b0;
    sel2   = 1'b0;
    sel_in = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_LOADA: begin
        ldA    = 1'b1;
        sel_in = 1'b1;
        busy   = 1'b1;
      end
      S_LOADB: begin
        ldB    = 1'b1;
        sel_in = 1'b1;
        busy   = 1'b1;
      end
      S_CHECK: busy = 1'b1;
      S_SUBA: begin
        ldA  = 1'b1;
        busy = 1'b1;
      end
      S_SUBB: begin
        ldB  = 1'b1;
        sel1 = 1'b1;
        sel2 = 1'b1;
        busy = 1'b1;
      end
      S_DONE: done = 1'b1;
      S_ERR:  err  = 1'b1;
      default: ;
    endcase
  end

  assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller with a behavioural GCD datapath.
// Scoreboard queue filled by the driver, drained by a negedge monitor.
module tb_gcd_controller;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        lt, gt, eq;
  logic        ldA, ldB, sel1, sel2, sel_in;
  logic        busy, done, err;
  logic [15:0] iter_cnt;

  gcd_controller #(
    .CNT_W   (16),
    .MAX_ITER(16'd8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .lt      (lt),
    .gt      (gt),
    .eq      (eq),
    .ldA     (ldA),
    .ldB     (ldB),
    .sel1    (sel1),
    .sel2    (sel2),
    .sel_in  (sel_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] ra = 16'd0, rb = 16'd0;
  logic [15:0] opa = 16'd0, opb = 16'd0;
  logic [15:0] din, sub;
  logic        force_en = 1'b0;
  logic        f_lt = 1'b0, f_gt = 1'b0, f_eq = 1'b0;

  assign din = ldB ? opb : opa;
  assign sub = (sel1 ? rb : ra) - (sel2 ? ra : rb);
  assign lt  = force_en ? f_lt : (ra < rb);
  assign gt  = force_en ? f_gt : (ra > rb);
  assign eq  = force_en ? f_eq : (ra == rb);

  always @(negedge clk) begin
    if (ldA) ra <= sel_in ? din : sub;
    if (ldB) rb <= sel_in ? din : sub;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int res;
    int n;
    bit is_err;
    int fin_edge;
    bit chk_res;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   subloads = 0;
  logic prev_fin = 1'b0;

  function automatic void chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if ((ldA || ldB) && !sel_in) subloads++;
    if ((done || err) && !prev_fin) begin
      if (q.size() == 0) begin
        chk("unexpected_finish", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done", done, !e.is_err);
        chk("err", err, e.is_err);
        chk("iter_cnt", iter_cnt, e.n);
        chk("subloads", subloads, e.n);
        chk("latency_edge", cyc + 1, e.fin_edge);
        if (e.chk_res) chk("result", ra, e.res);
      end
    end
    prev_fin = done || err;
  end

  task automatic run(input int a, input int b, input int res,
                     input int n, input bit is_err,
                     input bit chk_res, input int hold);
    int k;
    exp_t x;
    @(negedge clk);
    opa = a[15:0];
    opb = b[15:0];
    subloads = 0;
    x.res = res;
    x.n = n;
    x.is_err = is_err;
    x.fin_edge = cyc + 1 + 2 * n + 4;
    x.chk_res = chk_res;
    q.push_back(x);
    start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(done || err) && k < 300);
    chk("run_finished", done || err, 1);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_fin", done || err, 1);
      chk("hold_iter", iter_cnt, n);
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_fin", done || err, 0);
    chk("idle_iter", iter_cnt, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    start = 1'b0;
    #2;
    chk("rst_outs", {ldA, ldB, sel1, sel2, sel_in, busy, done, err}, 0);
    chk("rst_iter", iter_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(143, 78, 13, 6, 0, 1, 0);
    run(25, 25, 25, 0, 0, 1, 0);
    run(5, 0, 0, 8, 1, 0, 0);

    // abort in the second SUBB cycle of GCD(18,48)
    @(negedge clk);
    opa = 16'd18;
    opb = 16'd48;
    start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(ldB && !sel_in && iter_cnt == 16'd1) && k < 50);
    chk("reach_subb", ldB && !sel_in, 1);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs",
        {ldA, ldB, sel1, sel2, sel_in, busy, done, err}, 0);
    chk("async_rst_iter", iter_cnt, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    run(48, 18, 6, 4, 0, 1, 0);
    run(12, 8, 4, 2, 0, 1, 3);
    run(7, 21, 7, 2, 0, 1, 0);

    force_en = 1'b1;
    f_lt = 1'b0;
    f_gt = 1'b0;
    f_eq = 1'b0;
    run(3, 4, 0, 0, 1, 0, 0);
    f_gt = 1'b1;
    f_eq = 1'b1;
    run(9, 9, 9, 0, 0, 1, 0);
    force_en = 1'b0;

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM for the subtract-and-compare GCD datapath: two 16-bit operand registers (A, B), a subtractor, a comparator and operand/input muxes.
- Drives the datapath's load and select lines and consumes its lt/gt/eq status; the datapath is the other end of this control/status interface.
- Provides a start/done/err handshake to the system and an iteration timeout so zero operands cannot hang the engine.

Parameters:
- CNT_W, 16, width of the iteration counter.
- MAX_ITER, 16'hFFFF, max subtract iterations before abort; must fit in CNT_W bits.

Ports:
- clk  input  1  clock; controller state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a computation; level, sampled in IDLE.
- lt  input  1  datapath status, A < B.
- gt  input  1  datapath status, A > B.
- eq  input  1  datapath status, A == B.
- ldA  output  1  load enable for register A.
- ldB  output  1  load enable for register B.
- sel1  output  1  subtractor minuend mux: 0 = A, 1 = B.
- sel2  output  1  subtractor subtrahend mux: 0 = B, 1 = A.
- sel_in  output  1  register input mux: 1 = external data_in, 0 = subtractor output.
- busy  output  1  high in every state except IDLE, DONE and ERR.
- done  output  1  result valid in register A.
- err  output  1  iteration limit reached; result invalid.
- iter_cnt  output  CNT_W  subtract iterations performed in the current or last run.

Behaviour:
- Reset: clk and rst only, rst async active-high. While rst = 1: state = IDLE, all 1-bit outputs 0, iter_cnt = 0.
- Reset mid-operation returns to IDLE immediately. Datapath registers are not cleared, only left unloaded.
- All outputs are Moore (decoded from the registered state).
- Datapath registers capture on the falling edge inside the same cycle. Status is therefore settled before the next rising edge.
- States and outputs (unlisted outputs are 0):
  - IDLE: start = 1 -> LOADA, and iter_cnt cleared on that transition. Otherwise stay.
  - LOADA: ldA = 1, sel_in = 1. Producer must hold operand A on data_in this cycle. Next state LOADB.
  - LOADB: ldB = 1, sel_in = 1. Producer holds operand B. Next state CHECK.
  - CHECK: busy = 1. Decision priority is eq > gt > lt:
    - eq -> DONE.
    - else iter_cnt == MAX_ITER -> ERR.
    - else gt -> SUBA.
    - else lt -> SUBB.
    - No status bit set (illegal) -> ERR.
  - SUBA: ldA = 1, sel1 = 0, sel2 = 0, sel_in = 0 (A <= A - B). iter_cnt += 1. Next state CHECK.
  - SUBB: ldB = 1, sel1 = 1, sel2 = 1, sel_in = 0 (B <= B - A). iter_cnt += 1. Next state CHECK.
  - DONE: done = 1. Stay while start = 1; start = 0 -> IDLE.
  - ERR: err = 1. Stay while start = 1; start = 0 -> IDLE.
- busy = 1 in LOADA, LOADB, CHECK, SUBA, SUBB.
- start is ignored outside IDLE. A new run needs start low for at least one cycle after done/err (back in IDLE), then high again.
- Latency: with start sampled at rising edge 0, done/err rises at edge 2N+4, where N = iterations performed.
- iter_cnt saturates at MAX_ITER, never wraps, and holds its value in DONE/ERR/IDLE until the next start.
- Zero operand, e.g. A = 5, B = 0: the datapath never reaches eq, so the run ends in ERR after MAX_ITER iterations. A = B = 0 gives eq -> DONE with N = 0.

Test Plan:
- Controller plus the team's GCD datapath blocks, A = 143, B = 78 -> N = 6, iter_cnt = 6, done at edge 16, register A = 13, err = 0.
- A = B = 25 -> LOADA, LOADB, CHECK, DONE; done at edge 4, iter_cnt = 0, no subtract loads issued.
- MAX_ITER = 8, A = 5, B = 0 -> 8 SUBA cycles, err at edge 20, done = 0, iter_cnt = 8.
- Assert rst asynchronously mid-run (between edges, in a SUBB cycle) -> outputs 0 and state IDLE before the next edge. A new start then computes GCD(48,18) = 6 correctly.
- Hold start high through DONE -> stays in DONE, no second run. Drop start for 1 cycle, raise it with A = 7, B = 21 -> second run gives 7, iter_cnt = 2.
- Force illegal status lt = gt = eq = 0 in CHECK (standalone FSM bench) -> ERR on the next edge. Force eq = gt = 1 -> DONE (eq priority).
